// File: rtl/hrm_pkg.sv
// Shared definitions for the hrm register bank: source-select codes, error bit
// positions and the inbox-wait FSM encoding.
package hrm_pkg;

  localparam logic [1:0] MUX_INBOX   = 2'b00;
  localparam logic [1:0] MUX_MEM     = 2'b01;
  localparam logic [1:0] MUX_ALU     = 2'b11;
  localparam logic [1:0] MUX_ILLEGAL = 2'b10;

  localparam int ERR_W     = 3;
  localparam int ERR_MUX   = 0;
  localparam int ERR_BUSY  = 1;
  localparam int ERR_EMPTY = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_IN = 1'b1
  } state_t;

endpackage

// File: rtl/hrm_reg_cell.sv
// One working register: WIDTH-bit value plus a "holding something" flag.
// Loads in 1 cycle when ld is high; no backpressure.
module hrm_reg_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (ld) begin
      q   <= d;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/hrm_reg_bank.sv
// Bank of NREGS signed registers loaded from inbox/mem/ALU; 1-cycle write latency.
// Inbox loads stall in WAIT_IN (oBusy) until iInboxValid; errors are sticky.
module hrm_reg_bank
  import hrm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 1,
  parameter int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        iInbox,
  input  logic                    iInboxValid,
  output logic                    oInboxAck,
  input  logic [WIDTH-1:0]        iMem,
  input  logic [WIDTH-1:0]        iAlu,
  input  logic [1:0]              muxR,
  input  logic                    wR,
  input  logic [SEL_W-1:0]        wSel,
  input  logic [SEL_W-1:0]        rSel,
  input  logic                    rdChk,
  input  logic                    iErrClr,
  output logic signed [WIDTH-1:0] R,
  output logic                    oValid,
  output logic                    oBusy,
  output logic [ERR_W-1:0]        oErr
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   pend_q, pend_d;
  logic               we;
  logic [SEL_W-1:0]   we_sel;
  logic [WIDTH-1:0]   we_dat;
  logic [ERR_W-1:0]   err_set, err_q;
  logic [WIDTH-1:0]   rd_dat;
  logic               rd_vld;
  logic [WIDTH-1:0]   cell_q [NREGS];
  logic               cell_v [NREGS];
  logic               illegal;

  assign illegal = (muxR == MUX_ILLEGAL);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    we        = 1'b0;
    we_sel    = wSel;
    we_dat    = iInbox;
    oInboxAck = 1'b0;
    err_set   = '0;
    if (wR && illegal) err_set[ERR_MUX] = 1'b1;
    if (rdChk && !rd_vld) err_set[ERR_EMPTY] = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (wR && !illegal) begin
          case (muxR)
            MUX_MEM: begin
              we     = 1'b1;
              we_dat = iMem;
            end
            MUX_ALU: begin
              we     = 1'b1;
              we_dat = iAlu;
            end
            MUX_INBOX: begin
              if (iInboxValid) begin
                we        = 1'b1;
                oInboxAck = 1'b1;
              end else begin
                state_d = ST_WAIT_IN;
                pend_d  = wSel;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_IN: begin
        // New write requests are dropped while a load is outstanding.
        if (wR) err_set[ERR_BUSY] = 1'b1;
        if (iInboxValid) begin
          we        = 1'b1;
          we_sel    = pend_q;
          oInboxAck = 1'b1;
          state_d   = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      // Set beats clear for any bit raised in the same cycle.
      err_q   <= (iErrClr ? '0 : err_q) | err_set;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cell
    hrm_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .rst (rst),
      .ld  (we && (we_sel == SEL_W'(g))),
      .d   (we_dat),
      .q   (cell_q[g]),
      .vld (cell_v[g])
    );
  end

  always_comb begin
    rd_dat = '0;
    rd_vld = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rSel == SEL_W'(i)) begin
        rd_dat = cell_q[i];
        rd_vld = cell_v[i];
      end
    end
  end

  assign R      = rd_dat;
  assign oValid = rd_vld;
  assign oBusy  = (state_q == ST_WAIT_IN);
  assign oErr   = err_q;

`ifdef FORMAL
  always_comb begin
    assert (!$isunknown(R));
    assert (!oInboxAck || iInboxValid);
    assert (!(oBusy && we) || oInboxAck);
  end
`endif

endmodule

// File: tb/tb_hrm_reg_bank.sv
// Directed bench for hrm_reg_bank (WIDTH=8, NREGS=4) with an expected-value
// queue drained by a negedge monitor.
module tb_hrm_reg_bank;

  typedef struct packed {
    logic [7:0] r;
    logic       v;
    logic       b;
    logic       a;
    logic [2:0] e;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        iInbox, iMem, iAlu;
  logic              iInboxValid;
  logic              oInboxAck;
  logic [1:0]        muxR;
  logic              wR, rdChk, iErrClr;
  logic [1:0]        wSel, rSel;
  logic signed [7:0] R;
  logic              oValid, oBusy;
  logic [2:0]        oErr;

  exp_t  exp_q [$];
  string name_q [$];
  int    n_chk  = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  hrm_reg_bank #(.WIDTH(8), .NREGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .iInbox      (iInbox),
    .iInboxValid (iInboxValid),
    .oInboxAck   (oInboxAck),
    .iMem        (iMem),
    .iAlu        (iAlu),
    .muxR        (muxR),
    .wR          (wR),
    .wSel        (wSel),
    .rSel        (rSel),
    .rdChk       (rdChk),
    .iErrClr     (iErrClr),
    .R           (R),
    .oValid      (oValid),
    .oBusy       (oBusy),
    .oErr        (oErr)
  );

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_chk++;
      if ({R, oValid, oBusy, oInboxAck, oErr} === e)
        n_pass++;
      else
        $display("FAIL %s: got R=%h v=%b busy=%b ack=%b err=%b, expected R=%h v=%b busy=%b ack=%b err=%b",
                 nm, R, oValid, oBusy, oInboxAck, oErr, e.r, e.v, e.b, e.a, e.e);
    end
  end

  // Queue the outputs expected during this cycle, then clock; pulses drop after the edge.
  task automatic step(input string nm, input logic [7:0] r, input logic v,
                      input logic b, input logic a, input logic [2:0] e);
    exp_t x;
    x = '{r: r, v: v, b: b, a: a, e: e};
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    wR      = 1'b0;
    rdChk   = 1'b0;
    iErrClr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iInbox = '0; iMem = '0; iAlu = '0; iInboxValid = 1'b0;
    muxR = 2'b00; wR = 1'b0; wSel = '0; rSel = '0; rdChk = 1'b0; iErrClr = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 8'h00, 0, 0, 0, 3'b000);
    rst = 1'b0;

    // ALU write to reg2, read back, neighbour still empty
    wR = 1; muxR = 2'b11; iAlu = 8'h85; wSel = 2; rSel = 2;
    step("alu_wr_old", 8'h00, 0, 0, 0, 3'b000);
    step("alu_rd2", 8'h85, 1, 0, 0, 3'b000);
    rSel = 1;
    step("rd1_empty", 8'h00, 0, 0, 0, 3'b000);

    // Inbox load with stall, write attempt while busy, single ack
    wR = 1; muxR = 2'b00; wSel = 1; iInboxValid = 0;
    step("inb_req", 8'h00, 0, 0, 0, 3'b000);
    step("wait1", 8'h00, 0, 1, 0, 3'b000);
    wR = 1; muxR = 2'b01; iMem = 8'h11; wSel = 1;
    step("wait_wr", 8'h00, 0, 1, 0, 3'b000);
    muxR = 2'b00; iInboxValid = 1; iInbox = 8'h2A;
    step("capture", 8'h00, 0, 1, 1, 3'b010);
    step("post_cap", 8'h2A, 1, 0, 0, 3'b010);
    iInboxValid = 0; iErrClr = 1;
    step("clr_cyc", 8'h2A, 1, 0, 0, 3'b010);
    step("after_clr", 8'h2A, 1, 0, 0, 3'b000);

    // Illegal source leaves reg0 intact; empty read flagged
    wR = 1; muxR = 2'b01; iMem = 8'h07; wSel = 0; rSel = 0;
    step("mem_wr0", 8'h00, 0, 0, 0, 3'b000);
    step("rd0", 8'h07, 1, 0, 0, 3'b000);
    wR = 1; muxR = 2'b10; wSel = 0; iMem = 8'h55; iAlu = 8'h66; iInbox = 8'h77; iInboxValid = 1;
    step("illegal", 8'h07, 1, 0, 0, 3'b000);
    iInboxValid = 0;
    step("after_ill", 8'h07, 1, 0, 0, 3'b001);
    rSel = 3; rdChk = 1;
    step("rdchk3", 8'h00, 0, 0, 0, 3'b001);
    step("empty_err", 8'h00, 0, 0, 0, 3'b101);

    // Clear and a new illegal write in the same cycle
    iErrClr = 1; wR = 1; muxR = 2'b10; wSel = 1; rSel = 1;
    step("clr_ill", 8'h2A, 1, 0, 0, 3'b101);
    step("ill_wins", 8'h2A, 1, 0, 0, 3'b001);
    iErrClr = 1;
    step("clr2", 8'h2A, 1, 0, 0, 3'b001);
    step("clr2_done", 8'h2A, 1, 0, 0, 3'b000);

    // Write and read the same register in one cycle: no bypass
    wR = 1; muxR = 2'b11; iAlu = 8'hC3; wSel = 1; rSel = 1;
    step("same_old", 8'h2A, 1, 0, 0, 3'b000);
    step("same_new", 8'hC3, 1, 0, 0, 3'b000);

    // Reset in the middle of an inbox wait
    wR = 1; muxR = 2'b00; wSel = 3; rSel = 2; iInboxValid = 0;
    step("req2", 8'h85, 1, 0, 0, 3'b000);
    step("wait_b", 8'h85, 1, 1, 0, 3'b000);
    rst = 1;
    step("mid_rst", 8'h00, 0, 0, 0, 3'b000);
    rst = 0; iInboxValid = 1; iInbox = 8'h5A; rSel = 3;
    step("no_ack", 8'h00, 0, 0, 0, 3'b000);
    step("no_write3", 8'h00, 0, 0, 0, 3'b000);
    iInboxValid = 0; rSel = 2;
    step("reg2_clr", 8'h00, 0, 0, 0, 3'b000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d records left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
